// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU instruction and data channel bundle between
// an initiator (master) and the memory responder (slave).
interface mem_responder_if;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;

    modport master (
        output PC, Inst_Req_Valid, Inst_Ack,
        output Address, MemWrite, Write_data, Write_strb,
        output MemRead, Read_data_Ack,
        input  Inst_Req_Ack, Instruction, Inst_Valid,
        input  Mem_Req_Ack, Read_data, Read_data_Valid
    );

    modport slave (
        input  PC, Inst_Req_Valid, Inst_Ack,
        input  Address, MemWrite, Write_data, Write_strb,
        input  MemRead, Read_data_Ack,
        output Inst_Req_Ack, Instruction, Inst_Valid,
        output Mem_Req_Ack, Read_data, Read_data_Valid
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: word-array responder serving fetch/load/store one at a time.
// Define MEM_RANDOM_DELAY_EN for LFSR-driven per-request read latency.
module mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, ACK, WAIT, RESP} state_e;
    typedef enum logic [1:0] {FETCH, LOAD, STORE} kind_e;

    logic [31:0]           mem_q [DEPTH];
    state_e                state_q;
    kind_e                 kind_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [3:0]            cnt_q;
    logic                  iack_q;
    logic                  mack_q;
    logic                  ivalid_q;
    logic                  rvalid_q;
    logic [31:0]           inst_q;
    logic [31:0]           rdata_q;

    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic [ADDR_WIDTH-1:0] data_idx;
    logic [3:0]            lat_w;
    logic                  wr_en;
    logic                  enter_resp;
    logic                  resp_ack;
    logic                  unused_bits;

    assign fetch_idx = bus.PC[ADDR_WIDTH+1:2];
    assign data_idx  = bus.Address[ADDR_WIDTH+1:2];

    // Upper address bits wrap and the byte offset is ignored.
    assign unused_bits = ^{bus.PC[31:ADDR_WIDTH+2], bus.PC[1:0],
                           bus.Address[31:ADDR_WIDTH+2], bus.Address[1:0]};

`ifdef MEM_RANDOM_DELAY_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= {lfsr_q[6:0],
                       lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign lat_w = 4'd1 + {1'b0, lfsr_q[2:0]};
`else
    assign lat_w = 4'(LATENCY);
`endif

    assign wr_en = (state_q == IDLE) && bus.MemWrite;

    assign enter_resp =
        ((state_q == ACK) && (kind_q != STORE) && (lat_w == 4'd1)) ||
        ((state_q == WAIT) && (cnt_q == 4'd0));

    assign resp_ack = (kind_q == FETCH) ? bus.Inst_Ack : bus.Read_data_Ack;

    // Array is not reset; stores land on the IDLE->ACK edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.Write_strb[b]) begin
                    mem_q[data_idx][8*b +: 8] <= bus.Write_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            kind_q   <= FETCH;
            idx_q    <= '0;
            cnt_q    <= '0;
            iack_q   <= 1'b0;
            mack_q   <= 1'b0;
            ivalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            inst_q   <= '0;
            rdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.MemWrite) begin
                        kind_q  <= STORE;
                        idx_q   <= data_idx;
                        mack_q  <= 1'b1;
                        state_q <= ACK;
                    end else if (bus.MemRead) begin
                        kind_q  <= LOAD;
                        idx_q   <= data_idx;
                        mack_q  <= 1'b1;
                        state_q <= ACK;
                    end else if (bus.Inst_Req_Valid) begin
                        kind_q  <= FETCH;
                        idx_q   <= fetch_idx;
                        iack_q  <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    iack_q <= 1'b0;
                    mack_q <= 1'b0;
                    if (kind_q == STORE) begin
                        state_q <= IDLE;
                    end else if (lat_w == 4'd1) begin
                        state_q <= RESP;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= lat_w - 4'd2;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ack) begin
                        ivalid_q <= 1'b0;
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Word is captured once on RESP entry and held for all of RESP.
            if (enter_resp) begin
                if (kind_q == FETCH) begin
                    inst_q   <= mem_q[idx_q];
                    ivalid_q <= 1'b1;
                end else begin
                    rdata_q  <= mem_q[idx_q];
                    rvalid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.Inst_Req_Ack    = iack_q;
    assign bus.Mem_Req_Ack     = mack_q;
    assign bus.Inst_Valid      = ivalid_q;
    assign bus.Read_data_Valid = rvalid_q;
    assign bus.Instruction     = inst_q;
    assign bus.Read_data       = rdata_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: random fetch/load/store traffic against a cycle-schedule
// model of the responder, plus literal checks on the example transactions.
module tb_mem_responder;
    localparam int L       = 2;
    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    logic clk;
    logic rst_n;

    mem_responder_if bus();

    mem_responder #(.ADDR_WIDTH(8), .LATENCY(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [256];

    logic        chk_en = 1'b0;
    logic        e_iack = 1'b0;
    logic        e_mack = 1'b0;
    logic        e_ivalid = 1'b0;
    logic        e_rvalid = 1'b0;
    logic [31:0] e_inst = '0;
    logic [31:0] e_rdata = '0;

    int          cyc = 0;
    int          iack_cyc = 0;
    int          iv_cyc = 0;
    int          rv_last_cyc = 0;
    int          rv_run = 0;
    int          rv_len = 0;
    logic        prev_iv = 1'b0;
    logic [31:0] last_inst = '0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the schedule set by the driver.
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("inst_req_ack", 32'(bus.Inst_Req_Ack), 32'(e_iack));
            chk("mem_req_ack", 32'(bus.Mem_Req_Ack), 32'(e_mack));
            chk("inst_valid", 32'(bus.Inst_Valid), 32'(e_ivalid));
            chk("read_data_valid", 32'(bus.Read_data_Valid), 32'(e_rvalid));
            if (e_ivalid) chk("instruction", bus.Instruction, e_inst);
            if (e_rvalid) chk("read_data", bus.Read_data, e_rdata);
        end
        if (bus.Inst_Req_Ack) iack_cyc = cyc;
        if (bus.Inst_Valid && !prev_iv) iv_cyc = cyc;
        prev_iv = bus.Inst_Valid;
        if (bus.Inst_Valid) last_inst = bus.Instruction;
        if (bus.Read_data_Valid) begin
            last_rdata  = bus.Read_data;
            rv_last_cyc = cyc;
            rv_run++;
        end else if (rv_run != 0) begin
            rv_len = rv_run;
            rv_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Inst_Req_Valid = 1'b0;
        bus.MemRead        = 1'b0;
        bus.MemWrite       = 1'b0;
        bus.Inst_Ack       = 1'b0;
        bus.Read_data_Ack  = 1'b0;
        bus.PC             = '0;
        bus.Address        = '0;
        bus.Write_data     = '0;
        bus.Write_strb     = '0;
    endtask

    task automatic exp_clear();
        e_iack   = 1'b0;
        e_mack   = 1'b0;
        e_ivalid = 1'b0;
        e_rvalid = 1'b0;
    endtask

    task automatic noise(input logic [1:0] m);
        bus.Inst_Ack      = m[0] & 1'($urandom);
        bus.Read_data_Ack = m[1] & 1'($urandom);
    endtask

    // Entered in an IDLE cycle with the request already driven.
    task automatic serve(input int kind, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] st,
                         input int d);
        logic [7:0]  idx;
        logic [31:0] val;
        idx = a[9:2];
        tick();
        e_iack = (kind == K_FETCH);
        e_mack = (kind != K_FETCH);
        if (kind == K_STORE) begin
            for (int b = 0; b < 4; b++) begin
                if (st[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        noise(2'b11);
        tick();
        e_iack = 1'b0;
        e_mack = 1'b0;
        if (kind == K_FETCH) begin
            bus.Inst_Req_Valid = 1'b0;
        end else begin
            bus.MemWrite = 1'b0;
            bus.MemRead  = 1'b0;
        end
        if (kind == K_STORE) begin
            noise(2'b00);
            return;
        end
        val = model_mem[idx];
        for (int j = 2; j <= 2 + L + d; j++) begin
            if (j > 2) tick();
            if (j < 1 + L) begin
                noise(2'b11);
            end else if (j <= 1 + L + d) begin
                if (kind == K_FETCH) begin
                    e_ivalid          = 1'b1;
                    e_inst            = val;
                    bus.Inst_Ack      = (j == 1 + L + d);
                    bus.Read_data_Ack = 1'($urandom);
                end else begin
                    e_rvalid          = 1'b1;
                    e_rdata           = val;
                    bus.Read_data_Ack = (j == 1 + L + d);
                    bus.Inst_Ack      = 1'($urandom);
                end
            end else begin
                e_ivalid = 1'b0;
                e_rvalid = 1'b0;
                noise(2'b00);
            end
        end
    endtask

    task automatic run(input bit f, input bit l, input bit s,
                       input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input int d);
        bus.Inst_Req_Valid = f;
        bus.MemRead        = l;
        bus.MemWrite       = s;
        bus.PC             = pc;
        bus.Address        = addr;
        bus.Write_data     = wd;
        bus.Write_strb     = st;
        if (s) serve(K_STORE, addr, wd, st, d);
        else if (l) serve(K_LOAD, addr, wd, st, d);
        if (f) serve(K_FETCH, pc, wd, st, d);
    endtask

    task automatic reset_pulse();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("rst_flags", {28'd0, bus.Inst_Req_Ack, bus.Mem_Req_Ack,
                          bus.Inst_Valid, bus.Read_data_Valid}, 32'd0);
        chk("rst_instruction", bus.Instruction, 32'd0);
        chk("rst_read_data", bus.Read_data, 32'd0);
        idle_inputs();
        exp_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_en = 1'b1;
    endtask

    initial begin
        int req_mark;
        rst_n = 1'b1;
        idle_inputs();
        #2;
        reset_pulse();

        for (int w = 0; w < 256; w++) begin
            run(1'b0, 1'b0, 1'b1, '0, 32'(w) << 2, $urandom, 4'hF, 0);
        end
        run(1'b0, 1'b0, 1'b1, '0, 32'h0, 32'hCAFEF00D, 4'hF, 0);
        run(1'b0, 1'b0, 1'b1, '0, 32'h10, 32'h24020005, 4'hF, 0);
        run(1'b0, 1'b0, 1'b1, '0, 32'h20, 32'h11223344, 4'hF, 0);

        // Fetch of word 4: ack one cycle later, valid two cycles after ack.
        req_mark = cyc;
        run(1'b1, 1'b0, 1'b0, 32'h10, '0, '0, '0, 3);
        chk("fetch_ack_cycle", 32'(iack_cyc - req_mark), 32'd2);
        chk("fetch_valid_cycle", 32'(iv_cyc - req_mark), 32'd4);
        chk("fetch_word4", last_inst, 32'h24020005);

        // Partial-strobe store merge.
        run(1'b0, 1'b0, 1'b1, '0, 32'h20, 32'hAABBCCDD, 4'b0110, 0);
        run(1'b0, 1'b1, 1'b0, '0, 32'h20, '0, '0, 1);
        chk("store_merge", last_rdata, 32'h11BBCC44);

        // Simultaneous load and fetch: load served first.
        run(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, '0, '0, 1);
        chk("fetch_after_load", 32'(iack_cyc > rv_last_cyc), 32'd1);

        // Read_data_Ack held off for five RESP cycles.
        run(1'b0, 1'b1, 1'b0, '0, 32'h20, '0, '0, 5);
        tick();
        chk("resp_hold_len", 32'(rv_len), 32'd6);

        // Wrap-around of the word index.
        run(1'b0, 1'b1, 1'b0, '0, 32'h400, '0, '0, 0);
        chk("wrap_load", last_rdata, 32'hCAFEF00D);

        // Reset during WAIT of a load.
        run(1'b0, 1'b1, 1'b0, '0, 32'h10, '0, '0, 0);
        bus.MemRead = 1'b1;
        bus.Address = 32'h10;
        tick();
        e_mack = 1'b1;
        tick();
        e_mack = 1'b0;
        bus.MemRead = 1'b0;
        reset_pulse();
        repeat (8) tick();
        run(1'b0, 1'b1, 1'b0, '0, 32'h10, '0, '0, 0);
        chk("reread_after_reset", last_rdata, 32'h24020005);

        for (int n = 0; n < 250; n++) begin
            bit f, l, s;
            logic [2:0] k;
            k = 3'($urandom_range(1, 7));
            f = k[0];
            l = k[1];
            s = k[2];
            run(f, l, s, $urandom, $urandom, $urandom, 4'($urandom),
                int'($urandom_range(0, 4)));
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
